// File: rtl/echo_ranger_pkg.sv
// obstacle_pkg: FSM state encoding and default timing constants shared by the echo ranger.
package obstacle_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, MEASURE, DONE, WAIT_LOW, AVG} ranger_state_t;
  localparam int CYCLES_PER_CM_DEF  = 5800;
  localparam int TIMEOUT_CYCLES_DEF = 3_800_000;
endpackage

// File: rtl/echo_ranger_if.sv
// echo_ranger_if: trigger/echo inputs and distance/obstacle outputs of the echo ranger.
interface echo_ranger_if #(parameter int DIST_W = 9);
  logic              trig_i;
  logic              echo_i;
  logic [DIST_W-1:0] dist_cm;
  logic              dist_valid;
  logic              obstacle;
  logic              timeout_err;
  modport master (output trig_i, echo_i, input dist_cm, dist_valid, obstacle, timeout_err);
  modport slave  (input trig_i, echo_i, output dist_cm, dist_valid, obstacle, timeout_err);
endinterface

// File: rtl/echo_ranger_sync.sv
// echo_sync: 2-FF synchronizer for the raw echo pin with rise/fall pulses on the synchronized level.
module echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[1:0], async_i};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  // bit 2 is the previous synchronized level, used only for edge detection
  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/echo_ranger.sv
// echo_ranger: echo high-time to cm converter with hysteretic obstacle flag.
// Define RANGE_AVG_EN to report a 4-sample moving average instead of the raw reading.
module echo_ranger
  import obstacle_pkg::*;
#(
  parameter int CYCLES_PER_CM  = CYCLES_PER_CM_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int DIST_W         = 9,
  parameter int NEAR_CM        = 20,
  parameter int HYST_CM        = 3
) (
  input logic          clk,
  input logic          rst_n,
  echo_ranger_if.slave bus
);
  localparam int SUB_W = $clog2(CYCLES_PER_CM);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [DIST_W:0] NEAR_T = (DIST_W+1)'(NEAR_CM);
  localparam logic [DIST_W:0] CLR_T  = (DIST_W+1)'(NEAR_CM + HYST_CM);
`ifdef RANGE_AVG_EN
  localparam ranger_state_t AFTER_DONE = AVG;
`else
  localparam ranger_state_t AFTER_DONE = IDLE;
`endif
  ranger_state_t     state_q, state_d;
  logic              trig_q, trig_fall, echo_lvl, echo_rise, echo_fall;
  logic [SUB_W-1:0]  sub_cnt_q, sub_cnt_d;
  logic [DIST_W-1:0] cm_cnt_q, cm_cnt_d, dist_q, dist_d, new_dist;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              valid_q, valid_d, obst_q, obst_d, terr_q, terr_d;
  logic              load, tmo_fail, sub_wrap;
  echo_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.echo_i),
    .level_o (echo_lvl),
    .rise_o  (echo_rise),
    .fall_o  (echo_fall)
  );
  assign trig_fall = trig_q & ~bus.trig_i;
  assign sub_wrap  = sub_cnt_q == SUB_W'(CYCLES_PER_CM - 1);
  // an edge arriving on the last allowed cycle wins over the timeout
  assign tmo_fail  = tmo_q == TMO_W'(TIMEOUT_CYCLES - 1) &&
                     (state_q == ARMED && !echo_rise || state_q == MEASURE && !echo_fall);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = trig_fall ? ARMED : IDLE;
      ARMED:    state_d = echo_rise ? MEASURE : tmo_fail ? IDLE : ARMED;
      MEASURE:  state_d = echo_fall ? DONE : tmo_fail ? WAIT_LOW : MEASURE;
      DONE:     state_d = AFTER_DONE;
      WAIT_LOW: state_d = echo_lvl ? WAIT_LOW : IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    tmo_d     = (state_q == ARMED && !echo_rise || state_q == MEASURE) ? tmo_q + 1'b1 : '0;
    sub_cnt_d = state_q == ARMED ? '0 : state_q != MEASURE ? sub_cnt_q : sub_wrap ? '0 : sub_cnt_q + 1'b1;
    cm_cnt_d  = state_q == ARMED ? '0 :
                (state_q == MEASURE && sub_wrap && ~&cm_cnt_q) ? cm_cnt_q + 1'b1 : cm_cnt_q;
  end
`ifdef RANGE_AVG_EN
  logic [DIST_W-1:0] hist_q [4];
  logic [DIST_W-1:0] hist_d [4];
  logic [DIST_W+1:0] sum_q, sum_d;
  logic              fill_q, fill_d;
  always_comb begin
    hist_d = hist_q;
    sum_d  = sum_q;
    fill_d = fill_q | (state_q == DONE);
    if (state_q == DONE && fill_q) begin
      hist_d[0] = cm_cnt_q;
      hist_d[1] = hist_q[0];
      hist_d[2] = hist_q[1];
      hist_d[3] = hist_q[2];
      sum_d     = sum_q - (DIST_W+2)'(hist_q[3]) + (DIST_W+2)'(cm_cnt_q);
    end else if (state_q == DONE) begin
      for (int i = 0; i < 4; i++) hist_d[i] = cm_cnt_q;
      sum_d = {cm_cnt_q, 2'b00};
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hist_q <= '{default: '0};
      sum_q  <= '0;
      fill_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
    end
  assign load     = state_q == DONE;
  assign new_dist = sum_d[DIST_W+1:2];
`else
  // registering on the MEASURE->DONE edge makes dist_valid coincide with DONE
  assign load     = state_q == MEASURE && echo_fall;
  assign new_dist = cm_cnt_d;
`endif
  always_comb begin
    dist_d  = load ? new_dist : dist_q;
    valid_d = load;
    terr_d  = tmo_fail;
    obst_d  = tmo_fail ? 1'b0 : !load ? obst_q :
              ({1'b0, new_dist} < NEAR_T) ? 1'b1 : ({1'b0, new_dist} >= CLR_T) ? 1'b0 : obst_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      trig_q    <= 1'b0;
      tmo_q     <= '0;
      sub_cnt_q <= '0;
      cm_cnt_q  <= '0;
      dist_q    <= '0;
      valid_q   <= 1'b0;
      obst_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      trig_q    <= bus.trig_i;
      tmo_q     <= tmo_d;
      sub_cnt_q <= sub_cnt_d;
      cm_cnt_q  <= cm_cnt_d;
      dist_q    <= dist_d;
      valid_q   <= valid_d;
      obst_q    <= obst_d;
      terr_q    <= terr_d;
    end
  assign bus.dist_cm     = dist_q;
  assign bus.dist_valid  = valid_q;
  assign bus.obstacle    = obst_q;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_echo_ranger.sv
// tb_echo_ranger: randomized self-checking bench for echo_ranger, 9-bit and saturating 4-bit builds side by side.
module tb_echo_ranger;
  localparam int CPC  = 10;
  localparam int TMO  = 1000;
  localparam int NEAR = 20;
  localparam int HYST = 3;
`ifdef RANGE_AVG_EN
  localparam int LAT = 4;
  int hist_m [2][4];
  bit fill_m [2];
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  bit ob_m [2];
  echo_ranger_if #(.DIST_W(9)) ifc ();
  echo_ranger_if #(.DIST_W(4)) ifc4 ();
  assign ifc4.trig_i = ifc.trig_i;
  assign ifc4.echo_i = ifc.echo_i;
  echo_ranger #(.CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TMO), .DIST_W(9), .NEAR_CM(NEAR), .HYST_CM(HYST)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  echo_ranger #(.CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TMO), .DIST_W(4), .NEAR_CM(NEAR), .HYST_CM(HYST)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(ifc4.slave));
  always #5 clk = ~clk;
  task automatic model_reset();
    ob_m = '{1'b0, 1'b0};
`ifdef RANGE_AVG_EN
    fill_m = '{1'b0, 1'b0};
`endif
  endtask
  // reading = whole cm of echo high time, saturated to the output width, then optionally averaged over the last 4
  task automatic model_reading(input int n, output int e0, output int e1);
    int e [2];
    for (int i = 0; i < 2; i++) begin
      int raw;
      int mx;
      mx  = (i == 0) ? 511 : 15;
      raw = (n / CPC > mx) ? mx : n / CPC;
`ifdef RANGE_AVG_EN
      if (!fill_m[i]) for (int j = 0; j < 4; j++) hist_m[i][j] = raw;
      else begin
        for (int j = 0; j < 3; j++) hist_m[i][j] = hist_m[i][j+1];
        hist_m[i][3] = raw;
      end
      fill_m[i] = 1'b1;
      e[i] = (hist_m[i][0] + hist_m[i][1] + hist_m[i][2] + hist_m[i][3]) / 4;
`else
      e[i] = raw;
`endif
      if (e[i] < NEAR) ob_m[i] = 1'b1;
      else if (e[i] >= NEAR + HYST) ob_m[i] = 1'b0;
    end
    e0 = e[0];
    e1 = e[1];
  endtask
  task automatic do_trig();
    @(negedge clk) ifc.trig_i = 1'b1;
    @(negedge clk) ifc.trig_i = 1'b0;
  endtask
  task automatic run_meas(input int n, input string tag);
    int e [2];
    int lat [2];
    int cnt [2];
    int terr;
    logic [8:0] d [2];
    logic ob [2];
    do_trig();
    repeat ($urandom_range(2, 5)) @(negedge clk);
    ifc.echo_i = 1'b1;
    repeat (n) @(negedge clk);
    ifc.echo_i = 1'b0;
    model_reading(n, e[0], e[1]);
    lat = '{-1, -1};
    cnt = '{0, 0};
    terr = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ifc.dist_valid) begin cnt[0]++; if (lat[0] < 0) lat[0] = k; end
      if (ifc4.dist_valid) begin cnt[1]++; if (lat[1] < 0) lat[1] = k; end
      if (ifc.timeout_err || ifc4.timeout_err) terr++;
    end
    d[0] = ifc.dist_cm;
    d[1] = {5'd0, ifc4.dist_cm};
    ob[0] = ifc.obstacle;
    ob[1] = ifc4.obstacle;
    for (int i = 0; i < 2; i++) begin
      checks += 4;
      if (cnt[i] !== 1) begin failures++; $display("FAIL %s w%0d valid_pulses got %0d want 1", tag, i, cnt[i]); end
      if (lat[i] !== LAT) begin failures++; $display("FAIL %s w%0d latency got %0d want %0d", tag, i, lat[i], LAT); end
      if (d[i] !== 9'(e[i])) begin failures++; $display("FAIL %s w%0d dist_cm got %0d want %0d (echo %0d)", tag, i, d[i], e[i], n); end
      if (ob[i] !== ob_m[i]) begin failures++; $display("FAIL %s w%0d obstacle got %0b want %0b", tag, i, ob[i], ob_m[i]); end
    end
    checks++;
    if (terr !== 0) begin failures++; $display("FAIL %s spurious_timeout got %0d want 0", tag, terr); end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    ifc.trig_i = 1'b0;
    ifc.echo_i = 1'b0;
    repeat (3) @(negedge clk);
    checks += 2;
    if ({ifc.dist_cm, ifc.dist_valid, ifc.obstacle, ifc.timeout_err} !== 12'd0) begin
      failures++; $display("FAIL reset_outputs w9 got %h want 0", {ifc.dist_cm, ifc.dist_valid, ifc.obstacle, ifc.timeout_err}); end
    if ({ifc4.dist_cm, ifc4.dist_valid, ifc4.obstacle, ifc4.timeout_err} !== 7'd0) begin
      failures++; $display("FAIL reset_outputs w4 got %h want 0", {ifc4.dist_cm, ifc4.dist_valid, ifc4.obstacle, ifc4.timeout_err}); end
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask
  task automatic test_hysteresis();
    run_meas(200, "d20");
    run_meas(150, "d15");
    run_meas(215, "d21_hold");
    run_meas(230, "d23_clear");
    run_meas(159, "trunc15");
  endtask
  task automatic test_timeout_no_echo();
    int k = 0;
    int v = 0;
    bit seen = 0;
    run_meas(150, "pre_timeout");
    do_trig();
    while (!seen && k < 1100) begin
      @(negedge clk);
      k++;
      if (ifc.dist_valid || ifc4.dist_valid) v++;
      if (ifc.timeout_err) seen = 1;
    end
    ob_m = '{1'b0, 1'b0};
    checks += 4;
    if (!seen || k < 995 || k > 1005) begin failures++; $display("FAIL no_echo_timeout cycles got %0d want ~1001", k); end
    if (ifc4.timeout_err !== 1'b1) begin failures++; $display("FAIL no_echo_timeout w4 got %0b want 1", ifc4.timeout_err); end
    if (v !== 0) begin failures++; $display("FAIL no_echo_valid got %0d want 0", v); end
    if ({ifc.obstacle, ifc4.obstacle} !== 2'b00) begin failures++; $display("FAIL no_echo_obstacle got %b want 00", {ifc.obstacle, ifc4.obstacle}); end
    @(negedge clk);
    checks++;
    if (ifc.timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_pulse_width got %0b want 0", ifc.timeout_err); end
    run_meas(180, "after_no_echo");
  endtask
  task automatic test_long_echo();
    int k = 0;
    int v = 0;
    int extra = 0;
    bit seen = 0;
    run_meas(100, "pre_long");
    do_trig();
    repeat (3) @(negedge clk);
    ifc.echo_i = 1'b1;
    while (!seen && k < 1200) begin
      @(negedge clk);
      k++;
      if (ifc.dist_valid || ifc4.dist_valid) v++;
      if (ifc.timeout_err && ifc4.timeout_err) seen = 1;
    end
    ob_m = '{1'b0, 1'b0};
    checks += 2;
    if (!seen || k < 998 || k > 1008) begin failures++; $display("FAIL long_echo_timeout cycles got %0d want ~1003", k); end
    if ({ifc.obstacle, ifc4.obstacle} !== 2'b00) begin failures++; $display("FAIL long_echo_obstacle got %b want 00", {ifc.obstacle, ifc4.obstacle}); end
    for (int j = k; j < 5000; j++) begin
      @(negedge clk);
      ifc.trig_i = (j == 2000);
      if (ifc.dist_valid || ifc4.dist_valid) v++;
      if (ifc.timeout_err || ifc4.timeout_err) extra++;
    end
    ifc.echo_i = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ifc.dist_valid || ifc4.dist_valid) v++;
    end
    checks += 2;
    if (v !== 0) begin failures++; $display("FAIL long_echo_valid got %0d want 0", v); end
    if (extra !== 0) begin failures++; $display("FAIL long_echo_second_timeout got %0d want 0", extra); end
    run_meas(120, "after_long");
  endtask
  task automatic test_reset_mid();
    int v = 0;
    run_meas(150, "pre_reset");
    do_trig();
    repeat (3) @(negedge clk);
    ifc.echo_i = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 2;
    if ({ifc.dist_cm, ifc.dist_valid, ifc.obstacle, ifc.timeout_err} !== 12'd0) begin
      failures++; $display("FAIL mid_reset w9 got %h want 0", {ifc.dist_cm, ifc.dist_valid, ifc.obstacle, ifc.timeout_err}); end
    if ({ifc4.dist_cm, ifc4.dist_valid, ifc4.obstacle, ifc4.timeout_err} !== 7'd0) begin
      failures++; $display("FAIL mid_reset w4 got %h want 0", {ifc4.dist_cm, ifc4.dist_valid, ifc4.obstacle, ifc4.timeout_err}); end
    ifc.echo_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    ifc.echo_i = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (ifc.dist_valid || ifc4.dist_valid || ifc.timeout_err) v++;
    end
    ifc.echo_i = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ifc.dist_valid || ifc4.dist_valid || ifc.timeout_err) v++;
    end
    checks++;
    if (v !== 0) begin failures++; $display("FAIL echo_without_trig activity got %0d want 0", v); end
    run_meas(100, "post_reset_d10");
  endtask
  task automatic test_avg_sequence();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    run_meas(400, "seq40a");
    run_meas(400, "seq40b");
    run_meas(400, "seq40c");
    run_meas(5, "seq0");
  endtask
  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(1, 8)) @(negedge clk);
      run_meas($urandom_range(5, 900), "rand");
    end
  endtask
  initial begin
    test_reset();
    test_hysteresis();
    test_timeout_no_echo();
    test_long_echo();
    test_reset_mid();
    test_avg_sequence();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
